// File: rtl/ap_ctrl_chain_if.sv
// ap_ctrl_chain block-level handshake bundle between the chain driver and a kernel.
interface ap_ctrl_chain_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  // Driving end: issues starts and grants continues.
  modport master (output ap_start, output ap_continue, input ap_ready, input ap_done);
  // Kernel end: accepts starts and reports completions.
  modport slave  (input ap_start, input ap_continue, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain initiator: issues a programmed number of transactions with up to
// OUTSTANDING in flight, applies ap_continue back-pressure and records latency stats.
module ap_ctrl_chain_driver #(
  parameter int TRANS_W     = 16,
  parameter int CNT_W       = 32,
  parameter int DLY_W       = 4,
  parameter int OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  ap_ctrl_chain_if.master    kif,
  input  logic               i_go,
  input  logic [TRANS_W-1:0] i_cfg_num_trans,
  input  logic [DLY_W-1:0]   i_cfg_cont_delay,
  output logic               o_busy,
  output logic               o_finish,
  output logic [TRANS_W-1:0] o_issued_cnt,
  output logic [TRANS_W-1:0] o_done_cnt,
  output logic [CNT_W-1:0]   o_run_cycles,
  output logic [CNT_W-1:0]   o_lat_last,
  output logic [CNT_W-1:0]   o_lat_min,
  output logic [CNT_W-1:0]   o_lat_max,
  output logic               o_err_underflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int OCC_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0]   PTR_LAST     = PTR_W'(OUTSTANDING - 1);
  localparam logic [TRANS_W-1:0] MAX_INFLIGHT = TRANS_W'(OUTSTANDING);

  logic [1:0]         r_state;
  logic [TRANS_W-1:0] r_num_trans;
  logic [DLY_W-1:0]   r_cont_delay;
  logic [TRANS_W-1:0] r_issued_cnt;
  logic [TRANS_W-1:0] r_done_cnt;
  logic [CNT_W-1:0]   r_run_cycles;
  logic [DLY_W-1:0]   r_hold_cnt;
  logic               r_ap_start;
  logic [CNT_W-1:0]   r_lat_last;
  logic [CNT_W-1:0]   r_lat_min;
  logic [CNT_W-1:0]   r_lat_max;
  logic               r_err_underflow;

  // Start-timestamp FIFO; one entry per transaction between its start and completion.
  logic [CNT_W-1:0]   r_ts_mem [OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;

  logic               w_go;
  logic               w_accept;
  logic               w_complete;
  logic               w_last_done;
  logic               w_start_hold;
  logic               w_start_nxt;
  logic               w_push;
  logic               w_pop;
  logic [TRANS_W-1:0] w_issued_nxt;
  logic [TRANS_W-1:0] w_done_nxt;
  logic [TRANS_W-1:0] w_inflight_nxt;
  logic [CNT_W-1:0]   w_lat;

  assign w_go           = i_go && (r_state != S_RUN);
  assign w_accept       = r_ap_start && kif.ap_ready;
  assign kif.ap_continue = (r_state == S_RUN) && kif.ap_done && (r_hold_cnt >= r_cont_delay);
  assign w_complete     = kif.ap_continue;
  assign w_issued_nxt   = r_issued_cnt + TRANS_W'(w_accept);
  assign w_done_nxt     = r_done_cnt + TRANS_W'(w_complete);
  assign w_inflight_nxt = w_issued_nxt - w_done_nxt;
  assign w_last_done    = w_complete && (w_done_nxt == r_num_trans);
  assign w_start_hold   = r_ap_start && !w_accept;
  // A start that is not merely being held is a new transaction and needs a timestamp.
  assign w_push         = w_start_nxt && !w_start_hold;
  assign w_pop          = w_complete && (r_occ != '0);
  assign w_lat          = r_run_cycles - r_ts_mem[r_rd_ptr];

  // Decide whether ap_start is high next cycle: hold an unaccepted start, or issue a new one.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    w_start_nxt = 1'b0;
    if (r_state == S_RUN && !w_last_done) begin
      if (w_start_hold)
        w_start_nxt = 1'b1;
      else if (w_issued_nxt < r_num_trans && w_inflight_nxt < MAX_INFLIGHT)
        w_start_nxt = 1'b1;
    end
  end

  // Run control: FSM, configuration latch, transaction counters, continue hold timer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state      <= S_IDLE;
      r_num_trans  <= '0;
      r_cont_delay <= '0;
      r_issued_cnt <= '0;
      r_done_cnt   <= '0;
      r_run_cycles <= '0;
      r_hold_cnt   <= '0;
      r_ap_start   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_issued_cnt <= w_issued_nxt;
          r_done_cnt   <= w_done_nxt;
          r_run_cycles <= r_run_cycles + CNT_W'(1);
          r_ap_start   <= w_start_nxt;
          if (w_complete)
            r_hold_cnt <= '0;
          else if (kif.ap_done && !(&r_hold_cnt))
            r_hold_cnt <= r_hold_cnt + DLY_W'(1);
          if (w_last_done)
            r_state <= S_FIN;
        end
        default: begin
          r_ap_start <= 1'b0;
          if (i_go) begin
            r_num_trans  <= i_cfg_num_trans;
            r_cont_delay <= i_cfg_cont_delay;
            r_issued_cnt <= '0;
            r_done_cnt   <= '0;
            r_run_cycles <= '0;
            r_hold_cnt   <= '0;
            r_state      <= (i_cfg_num_trans == '0) ? S_FIN : S_RUN;
          end else if (r_state != S_FIN) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Timestamp FIFO pointers and occupancy; push and pop in one cycle are both applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (w_go) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  // Timestamp storage: the run_cycles value visible in the cycle the new start is presented.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers/occupancy alone define which entries are valid.
    if (w_push) r_ts_mem[r_wr_ptr] <= r_run_cycles + CNT_W'(1);
  end

  // Latency statistics and underflow flag, updated per completion and cleared by go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_last      <= '0;
      r_lat_min       <= '1;
      r_lat_max       <= '0;
      r_err_underflow <= 1'b0;
    end else if (w_go) begin
      r_lat_last      <= '0;
      r_lat_min       <= '1;
      r_lat_max       <= '0;
      r_err_underflow <= 1'b0;
    end else if (w_complete) begin
      if (r_occ == '0) begin
        r_err_underflow <= 1'b1;
      end else begin
        r_lat_last <= w_lat;
        if (w_lat < r_lat_min) r_lat_min <= w_lat;
        if (w_lat > r_lat_max) r_lat_max <= w_lat;
      end
    end
  end

  assign kif.ap_start     = r_ap_start;
  assign o_busy           = (r_state == S_RUN);
  assign o_finish         = (r_state == S_FIN);
  assign o_issued_cnt     = r_issued_cnt;
  assign o_done_cnt       = r_done_cnt;
  assign o_run_cycles     = r_run_cycles;
  assign o_lat_last       = r_lat_last;
  assign o_lat_min        = r_lat_min;
  assign o_lat_max        = r_lat_max;
  assign o_err_underflow  = r_err_underflow;

endmodule
